// File: rtl/fp_recip_result_buf.sv
// fp_recip_result_buf: result collector behind the pipelined FP reciprocal unit.
// Captures {z, status, arrive_id} on every push_out_n==0 into a small
// first-word-fall-through FIFO, throttles the pipeline with a registered
// accept_n, and presents the head entry over a valid/ready interface.
// Optional build macro FP_RECIP_RBUF_ID_CHECK_EN enables the sticky
// arrive_id sequence checker driving id_err; otherwise id_err is tied low.
module fp_recip_result_buf #(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int ID_WIDTH  = 8,
    parameter int DEPTH     = 4,
    parameter int SLACK     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               push_out_n,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]       z,
    input  logic [7:0]                         status,
    input  logic [ID_WIDTH-1:0]                arrive_id,
    output logic                               accept_n,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]       out_z,
    output logic [7:0]                         out_status,
    output logic [ID_WIDTH-1:0]                out_id,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               ovf,
    output logic                               id_err
);

    localparam int ZW = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int EW = ZW + 8 + ID_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Storage and control state; pointers carry a wrap bit so full != empty.
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] count_d;
    logic          ovf_q, ovf_d;
    logic          acc_q, acc_d;
    logic          push_req, pop, push_ok, drop, full;
    logic [EW-1:0] head;

    assign count     = wr_q - rd_q;
    assign out_valid = (count != '0);
    assign full      = (count == PW'(DEPTH));
    assign accept_n  = acc_q;
    assign ovf       = ovf_q;

    assign head       = mem_q[rd_q[AW-1:0]];
    assign out_z      = head[EW-1 -: ZW];
    assign out_status = head[ID_WIDTH +: 8];
    assign out_id     = head[ID_WIDTH-1:0];

    // Next-state: a push into a full FIFO is only taken when the head leaves
    // in the same cycle; flush overrides any same-cycle push or pop.
    always_comb begin
        push_req = ~push_out_n;
        pop      = out_valid & out_ready;
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        wr_d     = wr_q + PW'(push_ok);
        rd_d     = rd_q + PW'(pop);
        ovf_d    = ovf_q | drop;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            ovf_d = 1'b0;
        end
        count_d = wr_d - rd_d;
        acc_d   = (count_d >= PW'(DEPTH - SLACK));
    end

    // Control registers: pointers, sticky overflow and back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            acc_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
            acc_q <= acc_d;
        end
    end

    // Entry storage; cleared on reset so the head outputs are never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (!flush && push_ok) begin
            mem_q[wr_q[AW-1:0]] <= {z, status, arrive_id};
        end
    end

`ifdef FP_RECIP_RBUF_ID_CHECK_EN
    logic [ID_WIDTH-1:0] exp_id_q;
    logic                id_err_q;

    // ID sequence check: resync the expectation on every stored push so a
    // single gap flags once; dropped or flushed pushes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_id_q <= '0;
            id_err_q <= 1'b0;
        end else if (!flush && push_ok) begin
            exp_id_q <= arrive_id + 1'b1;
            if (arrive_id != exp_id_q) id_err_q <= 1'b1;
        end
    end

    assign id_err = id_err_q;
`else
    assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_recip_result_buf.sv
// Directed bench for fp_recip_result_buf with a queue-based reference model.
module tb_fp_recip_result_buf;

    localparam int DEPTH = 4;
    localparam int SLACK = 1;
`ifdef FP_RECIP_RBUF_ID_CHECK_EN
    localparam bit ID_CHK = 1'b1;
`else
    localparam bit ID_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        push_out_n = 1'b1;
    logic [31:0] z = '0;
    logic [7:0]  status = '0;
    logic [7:0]  arrive_id = '0;
    logic        accept_n, out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [7:0]  out_status, out_id;
    logic [2:0]  count;
    logic        ovf, id_err;

    int tests = 0;
    int fails = 0;

    fp_recip_result_buf #(
        .SIG_WIDTH(23), .EXP_WIDTH(8), .ID_WIDTH(8), .DEPTH(DEPTH), .SLACK(SLACK)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .push_out_n(push_out_n),
        .z(z), .status(status), .arrive_id(arrive_id), .accept_n(accept_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_status(out_status), .out_id(out_id), .count(count),
        .ovf(ovf), .id_err(id_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of stored results plus sticky flags.
    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  st;
        logic [7:0]  id;
    } ent_t;

    ent_t     m_q[$];
    bit       m_ovf = 0;
    bit       m_acc = 0;
    bit       m_iderr = 0;
    bit [7:0] m_exp = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_acc = 0; m_iderr = 0; m_exp = 0;
        end else if (flush) begin
            m_q.delete();
            m_ovf = 0; m_acc = 0;
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (!push_out_n) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back('{z: z, st: status, id: arrive_id});
                    if (ID_CHK) begin
                        if (arrive_id != m_exp) m_iderr = 1;
                        m_exp = arrive_id + 8'd1;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            m_acc = (m_q.size() >= DEPTH - SLACK);
        end
    end

    // Per-cycle comparison against the model, plus a log of popped IDs.
    logic [7:0] drain_q[$];

    always @(negedge clk) begin
        chk("count", 64'(count), 64'(m_q.size()));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("accept_n", 64'(accept_n), 64'(m_acc));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("id_err", 64'(id_err), 64'(m_iderr));
        if (m_q.size() != 0) begin
            chk("out_z", 64'(out_z), 64'(m_q[0].z));
            chk("out_status", 64'(out_status), 64'(m_q[0].st));
            chk("out_id", 64'(out_id), 64'(m_q[0].id));
        end
        if (!rst && out_valid && out_ready) drain_q.push_back(out_id);
    end

    task automatic step(input bit pn, input logic [31:0] zz, input logic [7:0] id,
                        input bit rdy, input bit fl);
        push_out_n = pn;
        z          = zz;
        status     = id ^ 8'hA5;
        arrive_id  = id;
        out_ready  = rdy;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] zid(input logic [7:0] id);
        return {24'h400000, id};
    endfunction

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out_z", 64'(out_z), 64'd0);
        rst = 1'b0;

        // Fill to the back-pressure threshold, then drain in order.
        for (int i = 0; i < 3; i++) step(0, zid(8'(i)), 8'(i), 0, 0);
        chk("fill_count", 64'(count), 64'd3);
        chk("fill_accept_n", 64'(accept_n), 64'd1);
        chk("fill_head_id", 64'(out_id), 64'd0);
        drain_q.delete();
        step(1, 0, 0, 1, 0);
        chk("drain1_accept_n", 64'(accept_n), 64'd0);
        chk("drain1_count", 64'(count), 64'd2);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_len", 64'(drain_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("drain_order", 64'(drain_q[i]), 64'(i));

        // Empty latency: no bypass, visible one cycle after the push edge.
        push_out_n = 0; z = 32'h3F000000; status = 8'h11; arrive_id = 8'd3; out_ready = 1;
        #1;
        chk("lat_valid_before", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_after", 64'(out_valid), 64'd1);
        chk("lat_out_z", 64'(out_z), 64'h3F000000);
        step(1, 0, 0, 1, 0);
        chk("lat_popped", 64'(count), 64'd0);
        step(0, zid(8'd4), 8'd4, 1, 0);
        step(1, 0, 0, 1, 0);

        // Full with simultaneous push and pop.
        for (int i = 5; i < 9; i++) step(0, zid(8'(i)), 8'(i), 0, 0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_accept_n", 64'(accept_n), 64'd1);
        drain_q.delete();
        step(0, zid(8'd9), 8'd9, 1, 0);
        chk("fullsim_count", 64'(count), 64'd4);
        chk("fullsim_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        chk("fullsim_len", 64'(drain_q.size()), 64'd5);
        chk("fullsim_last", 64'(drain_q[drain_q.size()-1]), 64'd9);

        // Overflow: fifth push dropped, then flush clears it.
        for (int i = 10; i < 15; i++) step(0, zid(8'(i)), 8'(i), 0, 0);
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_flag", 64'(ovf), 64'd1);
        drain_q.delete();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        chk("ovf_drain_len", 64'(drain_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("ovf_drain_id", 64'(drain_q[i]), 64'(10 + i));
        step(1, 0, 0, 0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ovf", 64'(ovf), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_accept_n", 64'(accept_n), 64'd0);

        // Asynchronous reset between edges with two entries held.
        step(0, zid(8'd14), 8'd14, 0, 0);
        step(0, zid(8'd15), 8'd15, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("pre_rst_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_accept_n", 64'(accept_n), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_id_err", 64'(id_err), 64'd0);
        chk("arst_out_z", 64'(out_z), 64'd0);
        chk("arst_out_status", 64'(out_status), 64'd0);
        chk("arst_out_id", 64'(out_id), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ID sequence 0,1,3,4: flags at the ID 3 push when checking is built in.
        step(0, zid(8'd0), 8'd0, 1, 0);
        step(0, zid(8'd1), 8'd1, 1, 0);
        chk("id_ok_before_gap", 64'(id_err), 64'd0);
        step(0, zid(8'd3), 8'd3, 1, 0);
        chk("id_err_gap", 64'(id_err), 64'(ID_CHK));
        step(0, zid(8'd4), 8'd4, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("id_err_sticky", 64'(id_err), 64'(ID_CHK));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_recip_result_buf.md
Name: fp_recip_result_buf

Overview:
- Downstream collector for the pipelined FP reciprocal unit.
- Captures each result the pipeline presents (push_out_n low), together with its status and ID, into a small FIFO.
- Throttles the pipeline through a registered accept_n back-pressure output.
- Hands results to the consumer over a valid/ready interface in arrival order.

Parameters:
- SIG_WIDTH, 23, significand width of the FP result.
- EXP_WIDTH, 8, exponent width; result word is SIG_WIDTH+EXP_WIDTH+1 bits.
- ID_WIDTH, 8, launch/arrive ID width.
- DEPTH, 4, FIFO entries; power of two, >=2.
- SLACK, 1, free entries reserved for pushes already committed when accept_n rises; 1 <= SLACK < DEPTH.

Ports:
- clk in 1: single clock, all logic rising-edge.
- rst in 1: reset, asynchronous and active-high.
- flush in 1: synchronous clear of FIFO contents and ovf.
- push_out_n in 1: active-low result-valid from the pipeline.
- z in SIG_WIDTH+EXP_WIDTH+1: result word.
- status in 8: result status flags.
- arrive_id in ID_WIDTH: ID of the presented result.
- accept_n out 1: registered back-pressure to the pipeline; 1 = stop pushing.
- out_valid out 1: head entry valid.
- out_ready in 1: consumer accepts the head entry.
- out_z out SIG_WIDTH+EXP_WIDTH+1: head result.
- out_status out 8: head status.
- out_id out ID_WIDTH: head ID.
- count out clog2(DEPTH)+1: occupancy.
- ovf out 1: sticky overflow flag.
- id_err out 1: sticky ID-sequence error (see Optional Feature).

Behaviour:
- Reset values while rst=1: all outputs 0, including accept_n, count, ovf and id_err; read/write pointers are 0.
- Push condition: push_out_n==0. Pop condition: out_valid && out_ready.
- Push stores {z,status,arrive_id} at the write pointer and advances it; pointers wrap modulo DEPTH.
- Storage is first-word-fall-through:
  - out_* always reflect the head entry.
  - out_valid = (count != 0).
  - No empty bypass: a push into an empty FIFO at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: both happen; the freed slot is reused and count stays DEPTH.
- Push while full without pop: data dropped, pointers and count unchanged, ovf set to 1 and held until rst or flush.
- Pop while empty: ignored.
- out_* hold when out_valid=0; contents are don't-care but must not be X after reset.
- accept_n is registered: at each edge accept_n <= (count_next >= DEPTH-SLACK), where count_next is the post-update occupancy.
- flush=1 at an edge:
  - Pointers, count and ovf go to 0; accept_n goes to 0.
  - Any same-cycle push/pop is discarded.
  - id_err is not cleared by flush.
- Arithmetic: count is 0..DEPTH; pointers carry one extra wrap bit internally so full and empty are distinguished.
- rst mid-operation: immediate return to reset values; pending data is lost.

Optional Feature:
- Macro: FP_RECIP_RBUF_ID_CHECK_EN.
- Defined:
  - An expected-ID register (reset 0) is compared with arrive_id on every accepted push.
  - Mismatch sets id_err, sticky until rst.
  - The expected ID becomes arrive_id+1 modulo 2^ID_WIDTH after every push, including mismatches, so one dropped ID flags once.
  - Dropped (overflow) pushes do not update the expected ID.
- Not defined: id_err tied to 0 and no checker logic is synthesized; the port remains.

Test Plan:
- Fill/drain: DEPTH=4, SLACK=1, out_ready=0, push IDs 0,1,2 -> count=3, accept_n=1 after the third push edge; out_valid=1 with out_id=0; raise out_ready -> IDs 0,1,2 emerge in order, accept_n returns 0 once count_next<3.
- Overflow: push 5 results with out_ready=0 -> count saturates at 4, ovf=1, fifth result absent from the drain sequence; flush -> count=0, ovf=0, out_valid=0.
- Full simultaneous: FIFO full, push ID 9 with out_ready=1 in the same cycle -> count stays 4, no ovf, ID 9 is the last entry drained.
- Empty latency: push z=32'h3F000000 into an empty FIFO with out_ready=1 -> out_valid low in that cycle, high next cycle with out_z=32'h3F000000, popped on that cycle.
- Async reset: assert rst between clock edges with count=2 -> all outputs 0 immediately, before the next edge.
- ID check (macro on): push IDs 0,1,3,4 -> id_err=1 after the ID 3 push and stays 1; with the macro off, the same stimulus gives id_err=0.
